// File: rtl/nn_pixel_replicator.sv
// Nearest-neighbour pre-expander: buffers one RGB888 source row, then replays it SCALE times
// with every pixel repeated SCALE times. Define REPLICATOR_MARKERS_EN to add sof/eol outputs.
module nn_pixel_replicator #(
  parameter int IMG_W = 384,
  parameter int IMG_H = 216,
  parameter int SCALE = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] s_pixel,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [23:0] pixel_out,
  output logic        output_valid,
  output logic        frame_done
`ifdef REPLICATOR_MARKERS_EN
  ,
  output logic        sof,
  output logic        eol
`endif
);

  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int REP_W = (SCALE > 1) ? $clog2(SCALE) : 1;

  localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_H - 1);
  localparam logic [REP_W-1:0] REP_MAX = REP_W'(SCALE - 1);

  typedef enum logic [1:0] {FILL, EMIT, GAP} state_t;

  state_t           state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic [REP_W-1:0] pass_q, pass_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             wr_en, rd_en, frame_end;

  logic [23:0] line_mem [IMG_W];
  logic [23:0] rd_data_q;
  logic        rd_vld_q, fd_stage_q;
  logic [23:0] pixel_out_q;
  logic        output_valid_q, frame_done_q;

  // s_ready is forced low while reset is asserted, even though state already reads FILL.
  assign s_ready = (state_q == FILL) && !rst;

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    rep_d     = rep_q;
    pass_d    = pass_q;
    row_d     = row_q;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    frame_end = 1'b0;
    case (state_q)
      FILL: begin
        if (s_valid && s_ready) begin
          wr_en = 1'b1;
          if (col_q == COL_MAX) begin
            col_d   = '0;
            state_d = EMIT;
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end
      EMIT: begin
        rd_en = 1'b1;
        if (rep_q == REP_MAX) begin
          rep_d = '0;
          if (col_q == COL_MAX) begin
            col_d   = '0;
            state_d = GAP;
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end else begin
          rep_d = rep_q + REP_W'(1);
        end
      end
      GAP: begin
        if (pass_q == REP_MAX) begin
          pass_d    = '0;
          state_d   = FILL;
          frame_end = (row_q == ROW_MAX);
          row_d     = frame_end ? '0 : row_q + ROW_W'(1);
        end else begin
          pass_d  = pass_q + REP_W'(1);
          state_d = EMIT;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      col_q   <= '0;
      rep_q   <= '0;
      pass_q  <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      rep_q   <= rep_d;
      pass_q  <= pass_d;
      row_q   <= row_d;
    end
  end

  // Line buffer: plain array with registered read so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) line_mem[col_q] <= s_pixel;
    if (rd_en) rd_data_q <= line_mem[col_q];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_vld_q       <= 1'b0;
      fd_stage_q     <= 1'b0;
      pixel_out_q    <= '0;
      output_valid_q <= 1'b0;
      frame_done_q   <= 1'b0;
    end else begin
      rd_vld_q       <= rd_en;
      fd_stage_q     <= frame_end;
      output_valid_q <= rd_vld_q;
      frame_done_q   <= fd_stage_q;
      if (rd_vld_q) pixel_out_q <= rd_data_q;
    end
  end

  assign pixel_out    = pixel_out_q;
  assign output_valid = output_valid_q;
  assign frame_done   = frame_done_q;

`ifdef REPLICATOR_MARKERS_EN
  logic sof_stage_q, eol_stage_q, sof_q, eol_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sof_stage_q <= 1'b0;
      eol_stage_q <= 1'b0;
      sof_q       <= 1'b0;
      eol_q       <= 1'b0;
    end else begin
      sof_stage_q <= rd_en && (row_q == '0) && (pass_q == '0) && (col_q == '0) && (rep_q == '0);
      eol_stage_q <= rd_en && (col_q == COL_MAX) && (rep_q == REP_MAX);
      sof_q       <= sof_stage_q;
      eol_q       <= eol_stage_q;
    end
  end

  assign sof = sof_q;
  assign eol = eol_q;
`endif

endmodule

// File: tb/tb_nn_pixel_replicator.sv
// Directed bench for nn_pixel_replicator: SCALE=3 instance (IMG_W=4, IMG_H=2) and a SCALE=1 instance.
// Marker checks are compiled in when REPLICATOR_MARKERS_EN is defined.
module tb_nn_pixel_replicator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] s_pixel = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [23:0] pixel_out;
  logic        output_valid, frame_done;

  logic [23:0] s_pixel_b = '0;
  logic        s_valid_b = 1'b0;
  logic        s_ready_b;
  logic [23:0] pixel_out_b;
  logic        output_valid_b, frame_done_b;

`ifdef REPLICATOR_MARKERS_EN
  logic sof, eol, sof_b, eol_b;
`endif

  nn_pixel_replicator #(.IMG_W(4), .IMG_H(2), .SCALE(3)) dut (
    .clk(clk), .rst(rst), .s_pixel(s_pixel), .s_valid(s_valid), .s_ready(s_ready),
    .pixel_out(pixel_out), .output_valid(output_valid), .frame_done(frame_done)
`ifdef REPLICATOR_MARKERS_EN
    , .sof(sof), .eol(eol)
`endif
  );

  nn_pixel_replicator #(.IMG_W(4), .IMG_H(2), .SCALE(1)) dut_b (
    .clk(clk), .rst(rst), .s_pixel(s_pixel_b), .s_valid(s_valid_b), .s_ready(s_ready_b),
    .pixel_out(pixel_out_b), .output_valid(output_valid_b), .frame_done(frame_done_b)
`ifdef REPLICATOR_MARKERS_EN
    , .sof(sof_b), .eol(eol_b)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int vtotal = 0;
  int last_acc = 0;
  int last_vcyc = 0;
  logic [23:0] outq[$];
  int vcyc[$];
  int fdq[$];
  int fdcyc[$];
  int sofq[$];
  int eolq[$];
  logic [23:0] outq_b[$];
  int vcyc_b[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (output_valid) begin
        outq.push_back(pixel_out);
        vcyc.push_back(cyc);
        vtotal++;
`ifdef REPLICATOR_MARKERS_EN
        if (sof) sofq.push_back(outq.size());
        if (eol) eolq.push_back(outq.size());
`endif
      end
      if (frame_done) begin
        fdq.push_back(vtotal);
        fdcyc.push_back(cyc);
      end
      if (output_valid_b) begin
        outq_b.push_back(pixel_out_b);
        vcyc_b.push_back(cyc);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_row();
    outq.delete();
    vcyc.delete();
    sofq.delete();
    eolq.delete();
  endtask

  // Drive one pixel (called #1 after a rising edge) and hold it until a handshake edge.
  task automatic feed(input logic [23:0] v, input bit stall_after);
    bit r;
    s_pixel = v;
    s_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      r = s_ready;
      @(posedge clk);
      #1;
      if (r) break;
    end
    last_acc = cyc;
    if (stall_after) begin
      s_valid = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_row(input int n);
    for (int i = 0; i < 600; i++) begin
      if (outq.size() >= n && s_ready) break;
      @(posedge clk);
      #1;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_row(input string nm, input logic [23:0] p0, input logic [23:0] p1,
                           input logic [23:0] p2, input logic [23:0] p3, input bit row0);
    logic [23:0] px [4];
    px[0] = p0; px[1] = p1; px[2] = p2; px[3] = p3;
    check({nm, "_count"}, outq.size(), 36);
    if (outq.size() >= 36) begin
      check({nm, "_latency"}, vcyc[0] - last_acc, 2);
      for (int k = 0; k < 36; k++)
        check($sformatf("%s_px%0d", nm, k), outq[k], px[(k % 12) / 3]);
      for (int k = 1; k < 36; k++)
        check($sformatf("%s_spacing%0d", nm, k), vcyc[k] - vcyc[k-1], ((k % 12) == 0) ? 2 : 1);
      last_vcyc = vcyc[35];
    end
`ifdef REPLICATOR_MARKERS_EN
    check({nm, "_sof_count"}, sofq.size(), row0 ? 1 : 0);
    if (row0 && sofq.size() > 0) check({nm, "_sof_pos"}, sofq[0], 1);
    check({nm, "_eol_count"}, eolq.size(), 3);
    if (eolq.size() == 3)
      for (int i = 0; i < 3; i++) check($sformatf("%s_eol%0d", nm, i), eolq[i], 12 * (i + 1));
`else
    if (row0) check({nm, "_row0_ready"}, s_ready, 1);
`endif
    $display("[TB] row %s: %0d outputs, %0d tests so far", nm, outq.size(), tests);
    clear_row();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_s_ready", s_ready, 0);
    check("rst_pixel_out", pixel_out, 0);
    check("rst_output_valid", output_valid, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_s_ready_b", s_ready_b, 0);
    rst = 1'b0;
    #1;
    check("post_rst_s_ready", s_ready, 1);

    // Row 1: s_valid held high, then AAAAAA held during emission.
    feed(24'h000001, 1'b0);
    feed(24'h000002, 1'b0);
    feed(24'h000003, 1'b0);
    feed(24'h000004, 1'b0);
    s_pixel = 24'hAAAAAA;
    for (int i = 0; i < 15; i++) begin
      if (i % 5 == 0) check($sformatf("emit_s_ready%0d", i), s_ready, 0);
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    wait_row(36);
    check_row("row1", 24'h000001, 24'h000002, 24'h000003, 24'h000004, 1'b1);
    check("fd_none_after_row1", fdq.size(), 0);

    // Row 2: stalled source, completes the frame.
    feed(24'h000011, 1'b1);
    feed(24'h000022, 1'b1);
    feed(24'h000033, 1'b1);
    feed(24'h000044, 1'b0);
    s_valid = 1'b0;
    wait_row(36);
    check_row("row2", 24'h000011, 24'h000022, 24'h000033, 24'h000044, 1'b0);
    check("fd_count1", fdq.size(), 1);
    if (fdq.size() >= 1) begin
      check("fd_at72", fdq[0], 72);
      check("fd_gap_aligned", fdcyc[0], last_vcyc + 1);
    end

    // Rows 3-4: second frame.
    feed(24'h123456, 1'b0);
    feed(24'h789ABC, 1'b0);
    feed(24'hDEF012, 1'b0);
    feed(24'h345678, 1'b0);
    s_valid = 1'b0;
    wait_row(36);
    check_row("row3", 24'h123456, 24'h789ABC, 24'hDEF012, 24'h345678, 1'b1);
    check("fd_count_row3", fdq.size(), 1);
    feed(24'hFF0000, 1'b0);
    feed(24'h00FF00, 1'b0);
    feed(24'h0000FF, 1'b0);
    feed(24'hFFFFFF, 1'b0);
    s_valid = 1'b0;
    wait_row(36);
    check_row("row4", 24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFFFF, 1'b0);
    check("fd_count2", fdq.size(), 2);
    if (fdq.size() >= 2) check("fd_at144", fdq[1], 144);

    // Reset during the 5th valid output of a row.
    feed(24'h5A0001, 1'b0);
    feed(24'h5A0002, 1'b0);
    feed(24'h5A0003, 1'b0);
    feed(24'h5A0004, 1'b0);
    s_valid = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (output_valid && outq.size() == 4) break;
    end
    check("rst_hit_5th", outq.size(), 4);
    check("rst_hit_valid", output_valid, 1);
    rst = 1'b1;
    #1;
    check("midrst_output_valid", output_valid, 0);
    check("midrst_pixel_out", pixel_out, 0);
    check("midrst_s_ready", s_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("after_rst_s_ready", s_ready, 1);
    clear_row();
    feed(24'h0BEEF1, 1'b0);
    feed(24'h0BEEF2, 1'b1);
    feed(24'h0BEEF3, 1'b0);
    feed(24'h0BEEF4, 1'b0);
    s_valid = 1'b0;
    wait_row(36);
    check_row("row6", 24'h0BEEF1, 24'h0BEEF2, 24'h0BEEF3, 24'h0BEEF4, 1'b1);
    check("fd_none_after_rst_row", fdq.size(), 2);
    feed(24'h000101, 1'b0);
    feed(24'h000202, 1'b0);
    feed(24'h000303, 1'b0);
    feed(24'h000404, 1'b0);
    s_valid = 1'b0;
    wait_row(36);
    check_row("row7", 24'h000101, 24'h000202, 24'h000303, 24'h000404, 1'b0);
    check("fd_count3", fdq.size(), 3);
    if (fdq.size() >= 3) check("fd_at220", fdq[2], 220);

    // SCALE=1 pass-through instance.
    s_valid_b = 1'b1;
    for (int p = 1; p <= 4; p++) begin
      s_pixel_b = 24'(p * 16'h10);
      check($sformatf("b_ready%0d", p), s_ready_b, 1);
      @(posedge clk);
      #1;
    end
    last_acc = cyc;
    s_valid_b = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("b_count", outq_b.size(), 4);
    if (outq_b.size() >= 4) begin
      check("b_latency", vcyc_b[0] - last_acc, 2);
      for (int k = 0; k < 4; k++) begin
        check($sformatf("b_px%0d", k), outq_b[k], 24'((k + 1) * 16'h10));
        if (k > 0) check($sformatf("b_spacing%0d", k), vcyc_b[k] - vcyc_b[k-1], 1);
      end
    end
    check("b_back_to_fill", s_ready_b, 1);
    check("b_hold_last", pixel_out_b, 24'h40);
    $display("[TB] scale1 row: %0d outputs", outq_b.size());

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
